state_sequence_monitor: RTL and testbench

- Receive-side checker for the 5-bit state-code stream produced by the team's next-state sequencer.
- Each valid cycle it samples the code and the mode bit A that was applied with it, then predicts the code the sequencer must produce next.
- Reports lock, mismatches and illegal codes, and decodes the code into a count value and a hold flag.
- Sits downstream of the sequencer output, on the same clock.

---
 rtl/state_seq_pkg.sv | 32 +++
 rtl/state_sequence_monitor_if.sv | 31 +++
 rtl/state_code_decoder.sv | 21 ++
 rtl/state_sequence_monitor.sv | 141 ++++++++++++++
 tb/tb_state_sequence_monitor.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/state_seq_pkg.sv
// Shared definitions for the state-code sequencer and its receive-side monitor.
// Holds the code constants, the monitor FSM encoding and the protocol rule
// expected_next(), which the sequencer's bench model reuses as-is.
package state_seq_pkg;

  localparam logic [4:0] ST_FIRST     = 5'd0;
  localparam logic [4:0] ST_TERM      = 5'd16;
  localparam logic [4:0] ST_ALT       = 5'd17;
  localparam logic [4:0] ST_MAX_LEGAL = 5'd17;

  typedef enum logic [1:0] {
    StUnlocked,
    StAcquire,
    StLocked
  } mon_state_e;

  // Code the sequencer must emit after 'code' was applied with mode bit 'a'.
  // Illegal codes carry no expectation; callers never compare against one.
  function automatic logic [4:0] expected_next(input logic [4:0] code, input logic a);
    logic [4:0] nxt;
    nxt = ST_FIRST;
    if (code > ST_MAX_LEGAL) begin
      nxt = ST_FIRST;
    end else if (a) begin
      nxt = (code == ST_ALT) ? ST_TERM : ST_ALT;
    end else begin
      nxt = (code < ST_TERM) ? code + 5'd1 : ST_FIRST;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/state_sequence_monitor_if.sv
// Bus between the sequencer output tap and the state sequence monitor.
//   valid, A, state      : sampled state/mode pair (driven by master)
//   count_value, in_hold : decoded view of the last valid code (driven by slave)
//   locked, mismatch,
//   illegal_code,
//   err_count            : monitor status (driven by slave)
interface state_sequence_monitor_if #(
  parameter int unsigned ERR_CNT_W = 8
);

  logic                 valid;
  logic                 A;
  logic [4:0]           state;
  logic [3:0]           count_value;
  logic                 in_hold;
  logic                 locked;
  logic                 mismatch;
  logic                 illegal_code;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output valid, A, state,
    input  count_value, in_hold, locked, mismatch, illegal_code, err_count
  );

  modport slave (
    input  valid, A, state,
    output count_value, in_hold, locked, mismatch, illegal_code, err_count
  );

endinterface

// File: rtl/state_code_decoder.sv
// Combinational decode of a 5-bit state code.
//   code_i        : state code
//   count_value_o : code[3:0] for codes 0..15, else 0
//   in_hold_o     : code is 16 or 17
//   is_illegal_o  : code is 18..31
module state_code_decoder
  import state_seq_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [3:0] count_value_o,
  output logic       in_hold_o,
  output logic       is_illegal_o
);

  always_comb begin
    count_value_o = (code_i < ST_TERM) ? code_i[3:0] : 4'd0;
    in_hold_o     = (code_i == ST_TERM) || (code_i == ST_ALT);
    is_illegal_o  = (code_i > ST_MAX_LEGAL);
  end

endmodule

// File: rtl/state_sequence_monitor.sv
// Receive-side checker for the sequencer's state-code stream. Each valid sample
// is compared with the code predicted from the previous sample and its mode bit;
// the monitor locks after LOCK_COUNT consecutive good transitions and reports
// mismatches (while locked) and illegal codes, counting both in a saturating
// error counter. All outputs are registered (1-cycle latency).
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of state_sequence_monitor_if (inputs valid/A/state,
//           outputs count_value/in_hold/locked/mismatch/illegal_code/err_count)
module state_sequence_monitor
  import state_seq_pkg::*;
#(
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  state_sequence_monitor_if.slave bus
);

  localparam logic [4:0] LockCnt = 5'(LOCK_COUNT);
  localparam logic [ERR_CNT_W-1:0] ErrOne = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  mon_state_e           fsm_q, fsm_d;
  logic [4:0]           ref_code_q, ref_code_d;
  logic                 ref_a_q, ref_a_d;
  logic [3:0]           good_cnt_q, good_cnt_d;
  logic [3:0]           count_value_q, count_value_d;
  logic                 in_hold_q, in_hold_d;
  logic                 mismatch_q, mismatch_d;
  logic                 illegal_q, illegal_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic [3:0] dec_count;
  logic       dec_hold;
  logic       dec_illegal;
  logic       match;
  logic       err_inc;
  logic [4:0] good_next;

  state_code_decoder u_decoder (
    .code_i        (bus.state),
    .count_value_o (dec_count),
    .in_hold_o     (dec_hold),
    .is_illegal_o  (dec_illegal)
  );

  assign match     = (bus.state == expected_next(ref_code_q, ref_a_q));
  assign good_next = {1'b0, good_cnt_q} + 5'd1;

  always_comb begin
    fsm_d         = fsm_q;
    ref_code_d    = ref_code_q;
    ref_a_d       = ref_a_q;
    good_cnt_d    = good_cnt_q;
    count_value_d = count_value_q;
    in_hold_d     = in_hold_q;
    mismatch_d    = 1'b0;
    illegal_d     = 1'b0;
    err_inc       = 1'b0;

    if (bus.valid) begin
      // Decoder already yields 0/0 for illegal codes.
      count_value_d = dec_count;
      in_hold_d     = dec_hold;
      ref_code_d    = bus.state;
      ref_a_d       = bus.A;

      if (dec_illegal) begin
        // Illegal wins over any mismatch; the next sample only re-seeds.
        illegal_d  = 1'b1;
        err_inc    = 1'b1;
        fsm_d      = StUnlocked;
        good_cnt_d = 4'd0;
      end else begin
        unique case (fsm_q)
          StUnlocked: begin
            good_cnt_d = 4'd0;
            fsm_d      = StAcquire;
          end
          StAcquire: begin
            if (match) begin
              good_cnt_d = good_next[3:0];
              if (good_next >= LockCnt) begin
                fsm_d = StLocked;
              end
            end else begin
              good_cnt_d = 4'd0;
            end
          end
          StLocked: begin
            if (!match) begin
              mismatch_d = 1'b1;
              err_inc    = 1'b1;
              fsm_d      = StAcquire;
              good_cnt_d = 4'd0;
            end
          end
          default: begin
            fsm_d      = StUnlocked;
            good_cnt_d = 4'd0;
          end
        endcase
      end
    end

    err_d = (err_inc && (err_q != '1)) ? err_q + ErrOne : err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q         <= StUnlocked;
      ref_code_q    <= 5'd0;
      ref_a_q       <= 1'b0;
      good_cnt_q    <= 4'd0;
      count_value_q <= 4'd0;
      in_hold_q     <= 1'b0;
      mismatch_q    <= 1'b0;
      illegal_q     <= 1'b0;
      err_q         <= '0;
    end else begin
      fsm_q         <= fsm_d;
      ref_code_q    <= ref_code_d;
      ref_a_q       <= ref_a_d;
      good_cnt_q    <= good_cnt_d;
      count_value_q <= count_value_d;
      in_hold_q     <= in_hold_d;
      mismatch_q    <= mismatch_d;
      illegal_q     <= illegal_d;
      err_q         <= err_d;
    end
  end

  assign bus.count_value  = count_value_q;
  assign bus.in_hold      = in_hold_q;
  assign bus.locked       = (fsm_q == StLocked);
  assign bus.mismatch     = mismatch_q;
  assign bus.illegal_code = illegal_q;
  assign bus.err_count    = err_q;

endmodule

// File: tb/tb_state_sequence_monitor.sv
// Directed bench for state_sequence_monitor (ERR_CNT_W=8, LOCK_COUNT=2).
// The driver pushes the hand-computed response for each valid sample into a
// queue; a separate monitor pops it one cycle later and compares.
module tb_state_sequence_monitor;

  typedef struct {
    logic [3:0] cnt;
    logic       hold;
    logic       lock;
    logic       mis;
    logic       ill;
    logic [7:0] err;
  } exp_t;

  logic clk;
  logic reset;
  logic sampled;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];

  state_sequence_monitor_if #(.ERR_CNT_W(8)) bus ();

  state_sequence_monitor #(
    .ERR_CNT_W  (8),
    .LOCK_COUNT (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic send(input logic a, input logic [4:0] code, input logic [3:0] cnt,
                      input logic hold, input logic lock, input logic mis,
                      input logic ill, input logic [7:0] err);
    exp_t e;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.A     = a;
    bus.state = code;
    e.cnt = cnt; e.hold = hold; e.lock = lock; e.mis = mis; e.ill = ill; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".count_value"}, 32'(bus.count_value), 32'd0);
    chk({tag, ".in_hold"}, 32'(bus.in_hold), 32'd0);
    chk({tag, ".locked"}, 32'(bus.locked), 32'd0);
    chk({tag, ".mismatch"}, 32'(bus.mismatch), 32'd0);
    chk({tag, ".illegal_code"}, 32'(bus.illegal_code), 32'd0);
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'd0);
  endtask

  // Monitor: a valid sample taken at a posedge is visible on the outputs after it.
  initial sampled = 1'b0;
  always @(posedge clk) sampled <= bus.valid && reset;

  always @(negedge clk) begin
    if (sampled) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("count_value", 32'(bus.count_value), 32'(e.cnt));
        chk("in_hold", 32'(bus.in_hold), 32'(e.hold));
        chk("locked", 32'(bus.locked), 32'(e.lock));
        chk("mismatch", 32'(bus.mismatch), 32'(e.mis));
        chk("illegal_code", 32'(bus.illegal_code), 32'(e.ill));
        chk("err_count", 32'(bus.err_count), 32'(e.err));
      end
    end else begin
      chk("idle.mismatch", 32'(bus.mismatch), 32'd0);
      chk("idle.illegal_code", 32'(bus.illegal_code), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int b;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    bus.valid = 1'b0;
    bus.A     = 1'b0;
    bus.state = 5'd0;

    repeat (2) @(negedge clk);
    check_reset("reset");
    reset = 1'b1;

    // Acquire and lock on an A=0 count
    send(0, 5'd0, 4'd0, 0, 0, 0, 0, 8'd0);
    send(0, 5'd1, 4'd1, 0, 0, 0, 0, 8'd0);
    send(0, 5'd2, 4'd2, 0, 1, 0, 0, 8'd0);
    send(0, 5'd3, 4'd3, 0, 1, 0, 0, 8'd0);
    idle(2);

    // Count up to the terminal code and wrap
    for (int i = 4; i <= 15; i++) send(0, 5'(i), 4'(i), 0, 1, 0, 0, 8'd0);
    send(0, 5'd16, 4'd0, 1, 1, 0, 0, 8'd0);
    send(0, 5'd0, 4'd0, 0, 1, 0, 0, 8'd0);

    // A=1 branch into the hold pair
    for (int i = 1; i <= 4; i++) send(0, 5'(i), 4'(i), 0, 1, 0, 0, 8'd0);
    send(1, 5'd5, 4'd5, 0, 1, 0, 0, 8'd0);
    send(1, 5'd17, 4'd0, 1, 1, 0, 0, 8'd0);
    send(1, 5'd16, 4'd0, 1, 1, 0, 0, 8'd0);
    send(0, 5'd17, 4'd0, 1, 1, 0, 0, 8'd0);
    send(0, 5'd0, 4'd0, 0, 1, 0, 0, 8'd0);

    // Skipped code while locked, then relock
    for (int i = 1; i <= 7; i++) send(0, 5'(i), 4'(i), 0, 1, 0, 0, 8'd0);
    send(0, 5'd9, 4'd9, 0, 0, 1, 0, 8'd1);
    send(0, 5'd10, 4'd10, 0, 0, 0, 0, 8'd1);
    send(0, 5'd11, 4'd11, 0, 1, 0, 0, 8'd1);

    // Illegal code, then re-seed without compare
    send(0, 5'd20, 4'd0, 0, 0, 0, 1, 8'd2);
    send(0, 5'd5, 4'd5, 0, 0, 0, 0, 8'd2);
    send(0, 5'd6, 4'd6, 0, 0, 0, 0, 8'd2);
    send(0, 5'd7, 4'd7, 0, 1, 0, 0, 8'd2);

    // 300 forced mismatches: bad start code, then two good steps to relock
    e = 2;
    for (int i = 0; i < 300; i++) begin
      b = (i % 2 == 1) ? 8 : 0;
      e = (e < 255) ? e + 1 : 255;
      send(0, 5'(b), 4'(b), 0, 0, 1, 0, 8'(e));
      send(0, 5'(b + 1), 4'(b + 1), 0, 0, 0, 0, 8'(e));
      send(0, 5'(b + 2), 4'(b + 2), 0, 1, 0, 0, 8'(e));
    end
    send(0, 5'd13, 4'd13, 0, 0, 1, 0, 8'd255);
    send(0, 5'd14, 4'd14, 0, 0, 0, 0, 8'd255);

    // Reset mid-acquisition, with valid high to exercise priority
    @(negedge clk);
    reset     = 1'b0;
    bus.valid = 1'b1;
    bus.state = 5'd15;
    @(negedge clk);
    bus.valid = 1'b0;
    check_reset("midreset");
    reset = 1'b1;
    send(0, 5'd15, 4'd15, 0, 0, 0, 0, 8'd0);
    send(0, 5'd16, 4'd0, 1, 0, 0, 0, 8'd0);
    send(0, 5'd0, 4'd0, 0, 1, 0, 0, 8'd0);
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
